// File: rtl/odd_pipe_pkg.sv
// odd_pipe_pkg: shared types, default latencies and the unit-to-latency helper for the odd-pipe scheduler.
package odd_pipe_pkg;

    typedef enum logic [1:0] {
        UNIT_PERM = 2'b00,
        UNIT_LS   = 2'b01,
        UNIT_BR   = 2'b10
    } unit_t;

    localparam int BR_LAT_D   = 1;
    localparam int PERM_LAT_D = 4;
    localparam int LS_LAT_D   = 6;
    localparam int SLOTS_D    = 7;
    localparam int CNT_W_D    = 16;
    localparam int RT_W       = 7;

    typedef struct packed {
        logic            valid;
        logic [RT_W-1:0] rt;
        logic            we;
    } res_entry_t;

    // Encoding 2'b11 is not a real unit and falls back to the permute latency.
    function automatic int lat_of(input logic [1:0] unit, input int br, input int perm, input int ls);
        return (unit == UNIT_LS) ? ls : (unit == UNIT_BR) ? br : perm;
    endfunction

endpackage

// File: rtl/wb_slot_table.sv
// wb_slot_table: writeback reservation shift register; entry k is the result reaching writeback k cycles from now.
module wb_slot_table
    import odd_pipe_pkg::*;
#(
    parameter int SLOTS = SLOTS_D,
    parameter int IDX_W = $clog2(SLOTS + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_ins_en,
    input  logic [IDX_W-1:0] i_ins_idx,
    input  res_entry_t       i_ins_entry,
    input  logic [IDX_W-1:0] i_busy_idx,
    output logic             o_busy,
    input  logic [RT_W-1:0]  i_addr_a,
    input  logic [RT_W-1:0]  i_addr_b,
    input  logic [RT_W-1:0]  i_addr_c,
    output logic [2:0]       o_raw_match
);

    res_entry_t r_res [1:SLOTS];

    // The insert lands after the shift so it overrides whatever slid into that slot.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 1; k <= SLOTS; k++) r_res[k] <= '0;
        end else begin
            for (int k = 1; k < SLOTS; k++) r_res[k] <= r_res[k+1];
            r_res[SLOTS] <= '0;
            if (i_ins_en) r_res[i_ins_idx] <= i_ins_entry;
        end
    end

    assign o_busy = r_res[i_busy_idx].valid;

    always_comb begin
        o_raw_match = '0;
        for (int k = 1; k <= SLOTS; k++) begin
            if (r_res[k].valid && r_res[k].we) begin
                if (r_res[k].rt == i_addr_a) o_raw_match[2] = 1'b1;
                if (r_res[k].rt == i_addr_b) o_raw_match[1] = 1'b1;
                if (r_res[k].rt == i_addr_c) o_raw_match[0] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/odd_pipe_issue_scheduler.sv
// odd_pipe_issue_scheduler: issues one odd-pipe instruction per cycle, stalling on RAW and
// writeback-slot collisions, and keeps saturating stall counters per cause.
module odd_pipe_issue_scheduler
    import odd_pipe_pkg::*;
#(
    parameter int BR_LAT   = BR_LAT_D,
    parameter int PERM_LAT = PERM_LAT_D,
    parameter int LS_LAT   = LS_LAT_D,
    parameter int SLOTS    = SLOTS_D,
    parameter int CNT_W    = CNT_W_D
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_unit,
    input  logic [6:0]       in_rt,
    input  logic [6:0]       in_ra,
    input  logic [6:0]       in_rb,
    input  logic [6:0]       in_rc,
    input  logic [2:0]       in_src_used,
    input  logic             in_reg_write,
    input  logic             flush,
    output logic             issue_valid,
    output logic [1:0]       issue_unit,
    output logic [6:0]       issue_rt,
    output logic             issue_reg_write,
    output logic [CNT_W-1:0] stall_raw_cnt,
    output logic [CNT_W-1:0] stall_struct_cnt
);

    localparam int IDX_W = $clog2(SLOTS + 1);

    logic [IDX_W-1:0] w_lat;
    logic [IDX_W-1:0] w_busy_idx;
    logic             w_struct;
    logic [2:0]       w_match;
    logic             w_raw;
    logic             w_accept;
    logic             w_stall;
    res_entry_t       w_entry;

    logic             r_issue_valid;
    logic [1:0]       r_issue_unit;
    logic [6:0]       r_issue_rt;
    logic             r_issue_we;
    logic [CNT_W-1:0] r_raw_cnt;
    logic [CNT_W-1:0] r_struct_cnt;

    assign w_lat      = IDX_W'(lat_of(in_unit, BR_LAT, PERM_LAT, LS_LAT));
    // The slot one further out is the one that becomes slot L once the table shifts at issue.
    assign w_busy_idx = w_lat + IDX_W'(1);
    assign w_raw      = |(w_match & in_src_used);
    assign in_ready   = !w_struct && !w_raw && !flush;
    assign w_accept   = in_valid && in_ready;
    assign w_stall    = in_valid && !flush && !in_ready;
    assign w_entry    = '{valid: 1'b1, rt: in_rt, we: in_reg_write};

    wb_slot_table #(
        .SLOTS (SLOTS),
        .IDX_W (IDX_W)
    ) u_table (
        .i_clock     (clock),
        .i_reset_n   (reset),
        .i_ins_en    (w_accept),
        .i_ins_idx   (w_lat),
        .i_ins_entry (w_entry),
        .i_busy_idx  (w_busy_idx),
        .o_busy      (w_struct),
        .i_addr_a    (in_ra),
        .i_addr_b    (in_rb),
        .i_addr_c    (in_rc),
        .o_raw_match (w_match)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_issue_valid <= 1'b0;
            r_issue_unit  <= '0;
            r_issue_rt    <= '0;
            r_issue_we    <= 1'b0;
        end else begin
            r_issue_valid <= w_accept;
            if (w_accept) begin
                r_issue_unit <= in_unit;
                r_issue_rt   <= in_rt;
                r_issue_we   <= in_reg_write;
            end
        end
    end

    // RAW takes the blame when both hazards are present.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_raw_cnt    <= '0;
            r_struct_cnt <= '0;
        end else if (w_stall) begin
            if (w_raw) begin
                if (!(&r_raw_cnt)) r_raw_cnt <= r_raw_cnt + CNT_W'(1);
            end else if (!(&r_struct_cnt)) begin
                r_struct_cnt <= r_struct_cnt + CNT_W'(1);
            end
        end
    end

    assign issue_valid      = r_issue_valid;
    assign issue_unit       = r_issue_unit;
    assign issue_rt         = r_issue_rt;
    assign issue_reg_write  = r_issue_we;
    assign stall_raw_cnt    = r_raw_cnt;
    assign stall_struct_cnt = r_struct_cnt;

endmodule

// File: tb/tb_odd_pipe_issue_scheduler.sv
// tb_odd_pipe_issue_scheduler: directed vector table plus hand-written reset and saturation sequences.
module tb_odd_pipe_issue_scheduler;

    typedef struct {
        logic        v;
        logic [1:0]  u;
        logic [6:0]  rt, ra, rb, rc;
        logic [2:0]  used;
        logic        we, fl;
        logic        rdy, iv;
        logic [1:0]  iu;
        logic [6:0]  irt;
        logic        iwe;
        logic [15:0] raw, st;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_unit = '0;
    logic [6:0]  in_rt = '0, in_ra = '0, in_rb = '0, in_rc = '0;
    logic [2:0]  in_src_used = '0;
    logic        in_reg_write = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid;
    logic [1:0]  issue_unit;
    logic [6:0]  issue_rt;
    logic        issue_reg_write;
    logic [15:0] stall_raw_cnt, stall_struct_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit wb_used[int];
    vec_t vt[$];

    odd_pipe_issue_scheduler dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_unit          (in_unit),
        .in_rt            (in_rt),
        .in_ra            (in_ra),
        .in_rb            (in_rb),
        .in_rc            (in_rc),
        .in_src_used      (in_src_used),
        .in_reg_write     (in_reg_write),
        .flush            (flush),
        .issue_valid      (issue_valid),
        .issue_unit       (issue_unit),
        .issue_rt         (issue_rt),
        .issue_reg_write  (issue_reg_write),
        .stall_raw_cnt    (stall_raw_cnt),
        .stall_struct_cnt (stall_struct_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // An issue seen in cycle c writes back in cycle c+L; no two issues may share that cycle.
    always @(negedge clock) begin
        cyc++;
        if (!reset) wb_used.delete();
        else if (issue_valid) begin
            int wb;
            wb = cyc + ((issue_unit == 2'b01) ? 6 : (issue_unit == 2'b10) ? 1 : 4);
            n_checks++;
            if (wb_used.exists(wb)) begin
                n_fail++;
                $display("FAIL wb_collision: issue at cycle %0d hits writeback cycle %0d already taken", cyc, wb);
            end
            wb_used[wb] = 1'b1;
        end
    end

    function automatic vec_t mk(input logic v, input logic [1:0] u, input logic [6:0] rt, ra, rb, rc,
                                input logic [2:0] used, input logic we, fl, rdy, iv,
                                input logic [1:0] iu, input logic [6:0] irt, input logic iwe,
                                input logic [15:0] raw, st);
        vec_t r;
        r.v = v; r.u = u; r.rt = rt; r.ra = ra; r.rb = rb; r.rc = rc; r.used = used;
        r.we = we; r.fl = fl; r.rdy = rdy; r.iv = iv; r.iu = iu; r.irt = irt; r.iwe = iwe;
        r.raw = raw; r.st = st;
        return r;
    endfunction

    function automatic vec_t idle(input logic rdy, input logic [1:0] iu, input logic [6:0] irt,
                                  input logic iwe, input logic [15:0] raw, st);
        return mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, rdy, 0, iu, irt, iwe, raw, st);
    endfunction

    task automatic drive(input vec_t r);
        in_valid = r.v; in_unit = r.u; in_rt = r.rt; in_ra = r.ra; in_rb = r.rb; in_rc = r.rc;
        in_src_used = r.used; in_reg_write = r.we; flush = r.fl;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_issue_valid"}, 32'(issue_valid), 0);
        chk({tag, "_issue_unit"}, 32'(issue_unit), 0);
        chk({tag, "_issue_rt"}, 32'(issue_rt), 0);
        chk({tag, "_issue_we"}, 32'(issue_reg_write), 0);
        chk({tag, "_raw_cnt"}, 32'(stall_raw_cnt), 0);
        chk({tag, "_struct_cnt"}, 32'(stall_struct_cnt), 0);
    endtask

    initial begin
        // Collision: LS at c0, permute stalls c2 and issues c3
        vt.push_back(mk(1, 1, 5, 0, 0, 0, 3'b000, 1, 0, 1, 1, 1, 5, 1, 0, 0));
        vt.push_back(idle(1, 1, 5, 1, 0, 0));
        vt.push_back(mk(1, 0, 9, 0, 0, 0, 3'b000, 1, 0, 0, 0, 1, 5, 1, 0, 1));
        vt.push_back(mk(1, 0, 9, 0, 0, 0, 3'b000, 1, 0, 1, 1, 0, 9, 1, 0, 1));
        repeat (4) vt.push_back(idle(1, 0, 9, 1, 0, 1));
        // LS, branch, permute: the permute must wait one cycle
        vt.push_back(mk(1, 1, 10, 0, 0, 0, 3'b000, 1, 0, 1, 1, 1, 10, 1, 0, 1));
        vt.push_back(mk(1, 2, 11, 0, 0, 0, 3'b000, 1, 0, 1, 1, 2, 11, 1, 0, 1));
        vt.push_back(mk(1, 0, 12, 0, 0, 0, 3'b000, 1, 0, 0, 0, 2, 11, 1, 0, 2));
        vt.push_back(mk(1, 0, 12, 0, 0, 0, 3'b000, 1, 0, 1, 1, 0, 12, 1, 0, 2));
        repeat (4) vt.push_back(idle(1, 0, 12, 1, 0, 2));
        // RAW on ra against LS rt=5: six stall cycles, RAW wins when both hazards overlap
        vt.push_back(mk(1, 1, 5, 0, 0, 0, 3'b000, 1, 0, 1, 1, 1, 5, 1, 0, 2));
        for (int j = 1; j <= 6; j++)
            vt.push_back(mk(1, 0, 20, 5, 0, 0, 3'b100, 1, 0, 0, 0, 1, 5, 1, 16'(j), 2));
        vt.push_back(mk(1, 0, 20, 5, 0, 0, 3'b100, 1, 0, 1, 1, 0, 20, 1, 6, 2));
        repeat (4) vt.push_back(idle(1, 0, 20, 1, 6, 2));
        // Producer without write enable creates no RAW hazard
        vt.push_back(mk(1, 1, 5, 0, 0, 0, 3'b000, 0, 0, 1, 1, 1, 5, 0, 6, 2));
        vt.push_back(mk(1, 0, 21, 5, 0, 0, 3'b100, 1, 0, 1, 1, 0, 21, 1, 6, 2));
        vt.push_back(idle(0, 0, 21, 1, 6, 2));
        repeat (4) vt.push_back(idle(1, 0, 21, 1, 6, 2));
        // Unused ra ignored; used rc matches
        vt.push_back(mk(1, 1, 5, 0, 0, 0, 3'b000, 1, 0, 1, 1, 1, 5, 1, 6, 2));
        vt.push_back(mk(1, 0, 22, 5, 1, 2, 3'b011, 1, 0, 1, 1, 0, 22, 1, 6, 2));
        vt.push_back(mk(1, 0, 23, 0, 0, 5, 3'b001, 0, 0, 0, 0, 0, 22, 1, 7, 2));
        // Flush: no issue, no count, no reservation for rt=24 (checked by next row's ra=24)
        vt.push_back(mk(1, 0, 24, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 22, 1, 7, 2));
        vt.push_back(mk(1, 3, 25, 24, 0, 0, 3'b100, 1, 0, 1, 1, 3, 25, 1, 7, 2));

        repeat (2) @(posedge clock);
        #1 chk_zero("reset");
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;
        foreach (vt[i]) begin
            drive(vt[i]);
            #4 chk($sformatf("ready[%0d]", i), 32'(in_ready), 32'(vt[i].rdy));
            @(posedge clock);
            #1;
            chk($sformatf("issue_valid[%0d]", i), 32'(issue_valid), 32'(vt[i].iv));
            chk($sformatf("issue_unit[%0d]", i), 32'(issue_unit), 32'(vt[i].iu));
            chk($sformatf("issue_rt[%0d]", i), 32'(issue_rt), 32'(vt[i].irt));
            chk($sformatf("issue_we[%0d]", i), 32'(issue_reg_write), 32'(vt[i].iwe));
            chk($sformatf("raw_cnt[%0d]", i), 32'(stall_raw_cnt), 32'(vt[i].raw));
            chk($sformatf("struct_cnt[%0d]", i), 32'(stall_struct_cnt), 32'(vt[i].st));
        end

        // Mid-stream reset with reservations for rt 5, 22 and 25 still live
        drive(idle(0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        #1 chk_zero("midreset");
        @(negedge clock) reset = 1'b1;
        drive(mk(1, 0, 30, 25, 22, 0, 3'b110, 1, 0, 1, 1, 0, 30, 1, 0, 0));
        #1 chk("post_reset_ready", 32'(in_ready), 1);
        @(posedge clock);
        #1;
        chk("post_reset_issue_valid", 32'(issue_valid), 1);
        chk("post_reset_issue_rt", 32'(issue_rt), 30);

        // Self-dependent LS stream: six RAW stalls per seven cycles drives the counter to saturation
        drive(mk(1, 1, 5, 5, 0, 0, 3'b100, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (80000) @(posedge clock);
        #1;
        chk("raw_saturated", 32'(stall_raw_cnt), 32'hFFFF);
        chk("struct_after_sat", 32'(stall_struct_cnt), 0);
        drive(idle(0, 0, 0, 0, 0, 0));
        @(posedge clock);
        #1;
        chk("raw_held", 32'(stall_raw_cnt), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/odd_pipe_issue_scheduler.md
Name: odd_pipe_issue_scheduler

Overview:
Issue-side scheduler for the odd pipeline, placed between decode/register-fetch and the odd pipe (permute, local store and branch units). It keeps a writeback-slot reservation table so that no two odd-pipe results reach writeback in the same cycle. It stalls read-after-write hazards against in-flight odd-pipe destinations, emits one registered issue per cycle, and counts stall cycles by cause.

Parameters:
BR_LAT, 1, cycles from issue_valid to writeback for the branch unit
PERM_LAT, 4, cycles from issue_valid to writeback for the permute unit
LS_LAT, 6, cycles from issue_valid to writeback for the local store unit
SLOTS, 7, reservation table depth; must equal max latency + 1
CNT_W, 16, stall counter width

Ports:
clock  in  1  single clock; all state on posedge clock
reset  in  1  asynchronous, active-low reset (reset==0 resets)
in_valid  in  1  decoded odd instruction presented
in_ready  out  1  scheduler accepts this cycle (combinational)
in_unit  in  2  00 permute, 01 local store, 10 branch, 11 treated as permute
in_rt  in  7  destination register
in_ra  in  7  source A address
in_rb  in  7  source B address
in_rc  in  7  store/third source address
in_src_used  in  3  {ra, rb, rc} used flags
in_reg_write  in  1  instruction writes rt
flush  in  1  branch taken; kill the candidate instruction this cycle
issue_valid  out  1  registered issue strobe to odd pipe
issue_unit  out  2  registered unit select
issue_rt  out  7  registered destination
issue_reg_write  out  1  registered write enable
stall_raw_cnt  out  CNT_W  saturating count of RAW stall cycles
stall_struct_cnt  out  CNT_W  saturating count of writeback-collision stall cycles

Behaviour:
- Reset (reset==0, async): issue_valid=0, issue_unit=0, issue_rt=0, issue_reg_write=0, both counters=0, all table entries invalid.
- Latency L is selected by in_unit: BR_LAT, PERM_LAT or LS_LAT.
- Table: entry res[k], k=1..SLOTS, holds {valid, rt, we}. It represents the result reaching writeback k cycles from now.
- Every cycle: res[k] <= res[k+1]; res[SLOTS] <= invalid.
- Structural hazard: res[L+1].valid. A decision at cycle t issues at t+1 and writes back at t+1+L.
- RAW hazard: any used source equals res[k].rt with res[k].valid & res[k].we, for any k in 1..SLOTS. Sources are compared regardless of in_reg_write. Results at k=0 are covered by forwarding.
- in_ready = !struct_hazard & !raw_hazard & !flush.
- Accept = in_valid & in_ready. On accept, the next res[L] = {1, in_rt, in_reg_write}, overriding the shift. Also on accept, issue_valid <= 1 and issue_* <= inputs.
- Otherwise issue_valid <= 0; the other issue_* outputs hold their values.
- Back-to-back accepts are allowed every cycle when hazards are absent. Only one write per table entry can occur per cycle.
- flush: has priority over accept. Nothing is issued, no reservation is made, and no stall is counted. Existing reservations are kept (conservative).
- Stall counting, when in_valid & !flush & !in_ready:
  - RAW hazard present: increment stall_raw_cnt (RAW wins if both hazards).
  - Otherwise: increment stall_struct_cnt.
  - Both counters saturate at all-ones and do not wrap.
- Reset asserted mid-operation clears all in-flight reservations immediately. The first cycle after deassertion can accept.

Decomposition:
- Package odd_pipe_pkg:
  - unit_t enum: UNIT_PERM=2'b00, UNIT_LS=2'b01, UNIT_BR=2'b10.
  - Latency constants.
  - res_entry_t struct {valid, rt[0:6], we}.
- Sub-module wb_slot_table:
  - Shift register of res_entry_t.
  - Insert port at a given index.
  - Lookup outputs: slot_busy for a given index, and a 3-bit RAW match for three addresses.
- Top level contains the hazard logic, the issue register and the counters.

Test Plan:
- Reset then idle: reset=0 mid-stream with 3 reservations live -> all outputs 0; after release, a permute at cycle 1 is accepted with in_ready=1.
- Collision: LS (rt=5) accepted t0, permute (rt=9, no sources) presented t2 -> in_ready=0 at t2 and stall_struct_cnt=1; accepted t3.
- No collision: LS t0, branch t1, permute t2 with distinct rt -> all three issue; writebacks at t7, t3, t7? Not allowed: the permute must stall at t2 and issue at t3. The bench checks that no two issues target the same writeback cycle.
- RAW: LS rt=5 we=1 accepted t0; permute ra=5 used presented from t1 -> in_ready=0 t1..t6, accepted t7, stall_raw_cnt=6.
- RAW ignored: same sequence with in_reg_write=0 on the LS, or with ra unused -> permute accepted t1, counters stay 0.
- Flush and saturation: flush=1 with in_valid=1 and no hazards -> issue_valid=0 next cycle, no reservation, counters unchanged. Forcing 70000 RAW stall cycles -> stall_raw_cnt=16'hFFFF.
